// File: rtl/counter_run_arbiter.sv
// Grant FSM that shares one WIDTH-bit counter between two requesters, runs it up or down
// to a latched terminal value and pulses done to the owner. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module counter_run_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] Q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             runDir_q, runDir_d;
  logic [WIDTH-1:0] runLen_q, runLen_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             winner;
  logic             ownerReq;
  logic [WIDTH-1:0] endValue;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastServed_q, lastServed_d;

  // On a tie the requester that was not served last wins; a lone request simply wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~lastServed_q;
    end else begin
      winner = req1 & ~req0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastServed_q <= 1'b1;
    end else begin
      lastServed_q <= lastServed_d;
    end
  end

  always_comb begin
    lastServed_d = lastServed_q;
    if (state_q == DONE) begin
      lastServed_d = owner_q;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    winner = ~req0;
  end
`endif

  assign ownerReq = owner_q ? req1 : req0;
  assign endValue = runDir_q ? runLen_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      runDir_q <= 1'b0;
      runLen_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      runDir_q <= runDir_d;
      runLen_q <= runLen_d;
      count_q  <= count_d;
    end
  end

  // The run parameters are captured at grant time so input changes mid-run have no effect.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    runDir_d = runDir_q;
    runLen_d = runLen_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = RUN;
          owner_d  = winner;
          runDir_d = winner ? dir1 : dir0;
          runLen_d = winner ? len1 : len0;
          if (winner ? dir1 : dir0) begin
            count_d = '0;
          end else begin
            count_d = winner ? len1 : len0;
          end
        end
      end
      RUN: begin
        if (!ownerReq) begin
          state_d = IDLE;
        end else if (count_q == endValue) begin
          state_d = DONE;
        end else if (runDir_q) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so nothing passes combinationally from the inputs.
  assign gnt0  = (state_q == RUN) && !owner_q;
  assign gnt1  = (state_q == RUN) && owner_q;
  assign done0 = (state_q == DONE) && !owner_q;
  assign done1 = (state_q == DONE) && owner_q;
  assign busy  = (state_q != IDLE);
  assign Q     = count_q;

endmodule
